truth_table_checker: RTL and testbench

Programmable N-input boolean function block with a built-in self-check sequencer. It evaluates a loadable truth table against a live input vector with a registered output. On request, it sweeps every input combination through an external combinational gate under test, compares the gate's response to the table and reports a mismatch bitmap, a count and a pass flag. It serves as the golden model and exhaustive checker for the team's small dataflow gates.

---
 rtl/truth_table_checker.sv | 136 +++++++++++++
 tb/tb_truth_table_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - loadable N-input truth table with exhaustive gate self-check sweep
//
// Purpose: holds a 2^N_IN-entry truth table, drives a registered live output f = table[in_vec],
// and on request sweeps every input index through an external gate under test, recording which
// indices disagree with the table.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_vec, f        live function input and its registered table lookup
//   tbl_wr_en/data   table load, honoured only while idle
//   sweep_start      request an exhaustive check
//   stim_vec/valid   stimulus to the gate under test, dut_f is its combinational response
//   busy, done       sweep in progress / one-cycle completion pulse
//   mismatch_map/cnt per-index disagreement bitmap and its popcount
//   pass             last completed sweep had no disagreements
module truth_table_checker #(
  parameter int                      N_IN        = 3,
  parameter int                      SETTLE      = 1,
  parameter logic [(2**N_IN)-1:0]    RESET_TABLE = 8'h45
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN-1:0]      in_vec,
  output logic                 f,
  input  logic                 tbl_wr_en,
  input  logic [(2**N_IN)-1:0] tbl_wr_data,
  input  logic                 sweep_start,
  output logic [N_IN-1:0]      stim_vec,
  output logic                 stim_valid,
  input  logic                 dut_f,
  output logic                 busy,
  output logic                 done,
  output logic [(2**N_IN)-1:0] mismatch_map,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 pass
);

  localparam int DEPTH = 2**N_IN;
  localparam int CW    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DEPTH-1:0]  tbl;
  logic [N_IN-1:0]   idx;
  logic [CW-1:0]     hold_cnt;
  logic              sample;
  logic              last_vec;
  logic              miss;
  logic [N_IN:0]     cnt_next;
  logic              accept_start;

  assign stim_vec     = idx;
  assign last_vec     = (idx == N_IN'(DEPTH - 1));
  assign miss         = (dut_f != tbl[idx]);
  // Count as it will stand after this sample; lets pass be valid in the done cycle.
  assign cnt_next     = miss ? mismatch_cnt + (N_IN+1)'(1) : mismatch_cnt;
  assign accept_start = (state == IDLE) && sweep_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    stim_valid = 1'b0;
    done       = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy       = 1'b1;
        stim_valid = 1'b1;
        sample     = (hold_cnt == '0);
        if (sample && last_vec) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl          <= RESET_TABLE;
      f            <= 1'b0;
      idx          <= '0;
      hold_cnt     <= '0;
      mismatch_map <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      f <= tbl[in_vec];

      // A write coinciding with sweep_start lands before the first sample, so the sweep sees it.
      if (state == IDLE && tbl_wr_en) begin
        tbl <= tbl_wr_data;
      end

      if (accept_start) begin
        idx          <= '0;
        hold_cnt     <= CW'(SETTLE);
        mismatch_map <= '0;
        mismatch_cnt <= '0;
        pass         <= 1'b0;
      end else if (state == DRIVE) begin
        if (sample) begin
          if (miss) begin
            mismatch_map[idx] <= 1'b1;
          end
          mismatch_cnt <= cnt_next;
          if (last_vec) begin
            // idx deliberately stays at the last index after the sweep.
            pass <= (cnt_next == '0);
          end else begin
            idx      <= idx + N_IN'(1);
            hold_cnt <= CW'(SETTLE);
          end
        end else begin
          hold_cnt <= hold_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [2:0] in_vec = '0;
  logic       f;
  logic       tbl_wr_en = 1'b0;
  logic [7:0] tbl_wr_data = '0;
  logic       sweep_start = 1'b0;
  logic [2:0] stim_vec;
  logic       stim_valid;
  logic       dut_f;
  logic       busy;
  logic       done;
  logic [7:0] mismatch_map;
  logic [3:0] mismatch_cnt;
  logic       pass;

  logic       stuck = 1'b0;
  logic [7:0] model_tbl = 8'h45;
  assign dut_f = stuck ? 1'b1 : model_tbl[stim_vec];

  logic       sweep_start_z = 1'b0;
  logic [2:0] stim_vec_z;
  logic       stim_valid_z;
  logic       dut_f_z;
  logic       busy_z;
  logic       done_z;
  logic [7:0] mismatch_map_z;
  logic [3:0] mismatch_cnt_z;
  logic       pass_z;
  logic       f_z;
  logic [7:0] model_tbl_z = 8'h45;
  assign dut_f_z = model_tbl_z[stim_vec_z];

  truth_table_checker #(.N_IN(3), .SETTLE(1), .RESET_TABLE(8'h45)) u_dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .f(f),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_data(tbl_wr_data), .sweep_start(sweep_start),
    .stim_vec(stim_vec), .stim_valid(stim_valid), .dut_f(dut_f),
    .busy(busy), .done(done), .mismatch_map(mismatch_map),
    .mismatch_cnt(mismatch_cnt), .pass(pass)
  );

  truth_table_checker #(.N_IN(3), .SETTLE(0), .RESET_TABLE(8'h45)) u_dut_z (
    .clk(clk), .rst(rst), .in_vec(3'd0), .f(f_z),
    .tbl_wr_en(1'b0), .tbl_wr_data(8'h00), .sweep_start(sweep_start_z),
    .stim_vec(stim_vec_z), .stim_valid(stim_valid_z), .dut_f(dut_f_z),
    .busy(busy_z), .done(done_z), .mismatch_map(mismatch_map_z),
    .mismatch_cnt(mismatch_cnt_z), .pass(pass_z)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] map;
    logic [3:0] cnt;
    logic       pass;
  } res_t;

  res_t sweep_q[$];
  logic f_q[$];

  task automatic push_sweep(input logic [7:0] t, input logic stk);
    res_t r;
    r.map = stk ? ~t : 8'h00;
    r.cnt = '0;
    for (int i = 0; i < 8; i++) r.cnt += {3'b0, r.map[i]};
    r.pass = (r.cnt == 0);
    sweep_q.push_back(r);
  endtask

  task automatic start(input logic wr, input logic [7:0] wd);
    @(posedge clk); #1;
    sweep_start = 1'b1;
    tbl_wr_en   = wr;
    tbl_wr_data = wd;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    tbl_wr_en   = 1'b0;
  endtask

  // Entered one step after the start edge; counts busy cycles until the done cycle.
  task automatic finish_sweep(input int exp_len, input int poke_wr, input int poke_st,
                              input logic restart_in_done);
    int   n;
    res_t r;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (n == 1) check("stim_valid", stim_valid, 1);
      tbl_wr_en   = (n == poke_wr);
      tbl_wr_data = 8'hFF;
      sweep_start = (n == poke_st);
      @(posedge clk); #1;
    end
    tbl_wr_en   = 1'b0;
    sweep_start = 1'b0;
    check("busy_len", n, exp_len);
    check("done_pulse", done, 1);
    if (sweep_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      r = sweep_q.pop_front();
      check("map", mismatch_map, r.map);
      check("cnt", mismatch_cnt, r.cnt);
      check("pass", pass, r.pass);
    end
    sweep_start = restart_in_done;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    check("done_one_cycle", done, 0);
    @(posedge clk); #1;
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int n;
    int done_seen;
    logic [7:0] live_tbl;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_f", f, 0);
    check("rst_stim_vec", stim_vec, 0);
    check("rst_stim_valid", stim_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_map", mismatch_map, 0);
    check("rst_cnt", mismatch_cnt, 0);
    check("rst_pass", pass, 0);
    rst = 1'b0;

    // Live path, one input per cycle, expected value one cycle later
    live_tbl = 8'h45;
    for (int i = 0; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        if (f_q.size() == 0) check("f_sb_empty", 1, 0);
        else check($sformatf("f_idx%0d", i - 1), f, f_q.pop_front());
      end
      if (i < 8) begin
        in_vec = 3'(i);
        f_q.push_back(live_tbl[i]);
      end
    end

    // Correct gate; sweep_start in done cycle must be ignored
    stuck = 1'b0;
    push_sweep(model_tbl, 1'b0);
    start(1'b0, 8'h00);
    finish_sweep(16, 0, 0, 1'b1);

    // Stuck-at-1 gate; results hold afterwards
    stuck = 1'b1;
    push_sweep(model_tbl, 1'b1);
    start(1'b0, 8'h00);
    finish_sweep(16, 0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("hold_map", mismatch_map, 8'hBA);
    check("hold_cnt", mismatch_cnt, 5);
    check("hold_pass", pass, 0);

    // Write during busy and sweep_start at busy cycle 5 are both ignored
    push_sweep(model_tbl, 1'b1);
    start(1'b0, 8'h00);
    finish_sweep(16, 2, 5, 1'b0);

    // Write together with start in idle: sweep uses the new table
    push_sweep(8'hFF, 1'b1);
    start(1'b1, 8'hFF);
    model_tbl = 8'hFF;
    finish_sweep(16, 0, 0, 1'b0);

    // Reset at vector 3
    start(1'b0, 8'h00);
    n = 0;
    while (stim_vec !== 3'd3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_vec3", stim_vec, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stim_vec", stim_vec, 0);
    check("mid_rst_cnt", mismatch_cnt, 0);
    check("mid_rst_map", mismatch_map, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    model_tbl = 8'h45;
    done_seen = 0;
    in_vec = 3'd1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("no_done_after_rst", done_seen, 0);
    check("rst_table_idx1", f, 0);
    in_vec = 3'd6;
    @(posedge clk); #1;
    check("rst_table_idx6", f, 1);

    // SETTLE=0 build, one vector per cycle
    @(posedge clk); #1;
    sweep_start_z = 1'b1;
    @(posedge clk); #1;
    sweep_start_z = 1'b0;
    n = 0;
    while (busy_z === 1'b1 && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    check("z_busy_len", n, 8);
    check("z_done", done_z, 1);
    check("z_cnt", mismatch_cnt_z, 0);
    check("z_map", mismatch_map_z, 0);
    check("z_pass", pass_z, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
